tlv5618_rx: RTL
===============

TLV5618_RX -- requirements
Module: tlv5618_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on dac_cs_n, dac_sclk and dac_din (minimum 2).
REQ-002 SHALL have parameter FRAME_BITS, default 16: bits per valid frame.
REQ-003 SHALL provide port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL provide ports dac_cs_n, dac_sclk and dac_din, each input, 1: the asynchronous serial inputs (chip select, serial clock, data).
REQ-006 SHALL provide ports dac_a, dac_b and buffer_q, each output, 12: DAC A latch, DAC B latch, double-buffer latch.
REQ-007 SHALL provide ports spd and pwr, each output, 1: last accepted speed bit and power-down bit.
REQ-008 SHALL provide port word_q, output, 16: last accepted raw frame.
REQ-009 SHALL provide port word_valid, output, 1: one-cycle pulse, frame accepted.
REQ-010 SHALL provide port frame_err, output, 1: one-cycle pulse, frame rejected.

Function
REQ-011 SHALL pass dac_cs_n, dac_sclk and dac_din through identical SYNC_STAGES flop chains, then a one-flop delay for edge detection; all logic SHALL use the synced signals only.
REQ-012 SHALL sample synced din on each detected SCLK falling edge while synced CS is low, shifting MSB first into a 16-bit shift register.
REQ-013 SHALL require each SCLK phase and each CS level to last at least 2 clk cycles; shorter input phases are unsupported.
REQ-014 SHALL implement states IDLE, SHIFT and OVER.
  - IDLE→SHIFT: CS falling edge; clear bit counter and shift register.
  - SHIFT→OVER: an SCLK falling edge arrives with the counter at FRAME_BITS.
  - SHIFT→IDLE or OVER→IDLE: CS rising edge.
REQ-015 SHALL, on CS rise in SHIFT with the counter equal to 16, accept the frame: word_q updates and word_valid pulses in the cycle after the CS rising edge is detected.
REQ-016 SHALL, on CS rise in SHIFT with the counter not equal to 16 (including 0), or on CS rise in OVER, pulse frame_err with the same latency and leave every latch unchanged.
REQ-017 SHALL decode accepted frames as D15=R1, D14=SPD, D13=PWR, D12=R0, D11..D0=data.
REQ-018 SHALL, for an accepted frame, update spd and pwr from D14 and D13 for every R1R0 code, including reserved.
REQ-019 SHALL, for R1R0=00, load data into dac_b and buffer_q.
REQ-020 SHALL, for R1R0=01, load data into buffer_q only.
REQ-021 SHALL, for R1R0=10, load data into dac_a and the old buffer_q value into dac_b, both in the same cycle.
REQ-022 SHALL, for R1R0=11 (reserved), leave dac_a, dac_b and buffer_q unchanged while still pulsing word_valid.
REQ-023 SHALL ignore SCLK edges while CS is high and never treat a CS edge as a data edge.
REQ-024 SHALL never assert word_valid and frame_err in the same cycle.
REQ-025 SHALL accept back-to-back frames with CS high for 2 clk cycles.

Reset
REQ-026 SHALL, on rst, set state IDLE; dac_a, dac_b, buffer_q and word_q to 0; spd, pwr, word_valid and frame_err to 0.
REQ-027 SHALL preset the synchronizer chains to idle levels: cs_n=1, sclk=1, din=0.
REQ-028 SHALL discard a partially received frame on reset mid-frame; if CS is still low after reset, SHALL remain IDLE until a fresh CS falling edge.

Structure
REQ-029 SHALL place in shared package tlv5618_pkg: R1R0 codes (WR_B_BUF=00, WR_BUF=01, WR_A_UPD_B=10, RSV=11), bit positions of R1/SPD/PWR/R0/data, FRAME_BITS and the state encoding.
REQ-030 SHALL use one sub-module, tlv5618_sync: a parameterized synchronizer with rise/fall pulse outputs, instantiated for CS and SCLK; DIN SHALL use its synced level only.

Verification
REQ-031 SHALL cover the driver-timed sequence 16'h1123, 16'h8456, 16'h0789 (SCLK 12.5 MHz, clk 50 MHz): after the second frame dac_a=456, dac_b=123; after the third dac_b=789 and buffer_q=789; three word_valid pulses.
REQ-032 SHALL cover 16'h4ABC, then 16'h2000: first spd=1, dac_b=ABC; then spd=0, pwr=1, dac_b=000, buffer_q=000.
REQ-033 SHALL cover reserved 16'h9FFF after REQ-031: word_valid=1, word_q=9FFF, all latches unchanged.
REQ-034 SHALL cover a 12-bit frame, a 17-bit frame and a CS low/high pulse with no SCLK: one frame_err each, no word_valid, latches unchanged.
REQ-035 SHALL cover rst asserted after bit 8 of 16'h8FFF with CS held low, then the remaining bits and CS rise: no word_valid, no frame_err, all outputs 0; the next full frame is accepted.

Source files
------------

// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 serial-frame receiver: frame layout,
// control codes and receiver state encoding.
package tlv5618_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned DATA_W     = 12;

  localparam int unsigned R1_BIT   = 15;
  localparam int unsigned SPD_BIT  = 14;
  localparam int unsigned PWR_BIT  = 13;
  localparam int unsigned R0_BIT   = 12;
  localparam int unsigned DATA_MSB = 11;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [1:0] {
    WR_B_BUF   = 2'b00,
    WR_BUF     = 2'b01,
    WR_A_UPD_B = 2'b10,
    RSV        = 2'b11
  } r1r0_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    OVER  = 2'b10
  } state_e;

  function automatic r1r0_e frame_code(input logic [WORD_W-1:0] w);
    return r1r0_e'({w[R1_BIT], w[R0_BIT]});
  endfunction

  function automatic logic [DATA_W-1:0] frame_data(input logic [WORD_W-1:0] w);
    return w[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/tlv5618_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by a delay flop
// that yields single-cycle rise/fall pulses on the synchronized level.
module tlv5618_sync #(
  parameter int unsigned STAGES = 2,
  parameter logic        INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{INIT}};
      dly_q   <= INIT;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
      dly_q   <= chain_q[STAGES-1];
    end
  end

  always_comb begin
    level = chain_q[STAGES-1];
    rise  = chain_q[STAGES-1] & ~dly_q;
    fall  = ~chain_q[STAGES-1] & dly_q;
  end

endmodule

// File: rtl/tlv5618_rx.sv
// Receiver for TLV5618 DAC serial frames: oversamples CS/SCLK/DIN with the
// system clock, assembles 16-bit words and applies them to the DAC latches.
module tlv5618_rx
  import tlv5618_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = tlv5618_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dac_cs_n,
  input  logic              dac_sclk,
  input  logic              dac_din,
  output logic [DATA_W-1:0] dac_a,
  output logic [DATA_W-1:0] dac_b,
  output logic [DATA_W-1:0] buffer_q,
  output logic              spd,
  output logic              pwr,
  output logic [WORD_W-1:0] word_q,
  output logic              word_valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam int unsigned FLUSH_LEN = SYNC_STAGES + 1;
  localparam int unsigned FLUSH_W = $clog2(FLUSH_LEN + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(FLUSH_LEN);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] din_q;
  logic din_s;

  tlv5618_sync #(
    .STAGES(SYNC_STAGES),
    .INIT  (1'b1)
  ) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .async_in(dac_cs_n),
    .level   (cs_lvl),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  tlv5618_sync #(
    .STAGES(SYNC_STAGES),
    .INIT  (1'b1)
  ) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .async_in(dac_sclk),
    .level   (sclk_lvl),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Only the falling SCLK edge carries data.
  logic unused_sclk;
  assign unused_sclk = sclk_lvl ^ sclk_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
    end else begin
      din_q <= {din_q[SYNC_STAGES-2:0], dac_din};
    end
  end
  assign din_s = din_q[SYNC_STAGES-1];

  // After reset the CS chain refills from its idle preset; a CS already held
  // low would look like a fresh falling edge, so ignore edges until it settles.
  logic [FLUSH_W-1:0] flush_q;
  logic               flush_done;
  assign flush_done = (flush_q == FLUSH_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q <= '0;
    end else if (!flush_done) begin
      flush_q <= flush_q + 1'b1;
    end
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dac_a_q, dac_a_d;
  logic [DATA_W-1:0] dac_b_q, dac_b_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] word_d;
  logic              spd_q, spd_d;
  logic              pwr_q, pwr_d;
  logic [WORD_W-1:0] word_r;
  logic              word_valid_q, word_valid_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    dac_a_d      = dac_a_q;
    dac_b_d      = dac_b_q;
    buf_d        = buf_q;
    word_d       = word_r;
    spd_d        = spd_q;
    pwr_d        = pwr_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall && flush_done) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            word_valid_d = 1'b1;
            word_d       = shift_q;
            spd_d        = shift_q[SPD_BIT];
            pwr_d        = shift_q[PWR_BIT];
            unique case (frame_code(shift_q))
              WR_B_BUF: begin
                dac_b_d = frame_data(shift_q);
                buf_d   = frame_data(shift_q);
              end
              WR_BUF: buf_d = frame_data(shift_q);
              WR_A_UPD_B: begin
                dac_a_d = frame_data(shift_q);
                dac_b_d = buf_q;
              end
              RSV: ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_fall && !cs_lvl) begin
          if (cnt_q == CNT_FULL) begin
            state_d = OVER;
          end else begin
            shift_d = {shift_q[WORD_W-2:0], din_s};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      dac_a_q      <= '0;
      dac_b_q      <= '0;
      buf_q        <= '0;
      word_r       <= '0;
      spd_q        <= 1'b0;
      pwr_q        <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dac_a_q      <= dac_a_d;
      dac_b_q      <= dac_b_d;
      buf_q        <= buf_d;
      word_r       <= word_d;
      spd_q        <= spd_d;
      pwr_q        <= pwr_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dac_a      = dac_a_q;
  assign dac_b      = dac_b_q;
  assign buffer_q   = buf_q;
  assign word_q     = word_r;
  assign spd        = spd_q;
  assign pwr        = pwr_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;

endmodule
